// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry instruction prefetch buffer between the IF stage and decode.
// Ports: clk, R_n, rom_addr/rom_data, branch/branch_target, id_ready, id_*, count, full, empty.
module fetch_queue #(
  parameter int ADDR_W   = 8,
  parameter int INSTR_W  = 32,
  parameter int DEPTH    = 4,
  parameter int PC_STEP  = 4,
  parameter int RESET_PC = 0
) (
  input  logic                         clk,
  input  logic                         R_n,
  output logic [ADDR_W-1:0]            rom_addr,
  input  logic [INSTR_W-1:0]           rom_data,
  input  logic                         branch,
  input  logic [ADDR_W-1:0]            branch_target,
  input  logic                         id_ready,
  output logic                         id_valid,
  output logic [INSTR_W-1:0]           id_instr,
  output logic [ADDR_W-1:0]            id_next_pc,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  npc;
  } ent_t;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] pc_inc;
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [CW-1:0]     cnt;
  logic              pop;
  logic              push;
  ent_t              mem [DEPTH];
  ent_t              head_e;

  // Pointers wrap explicitly so non power-of-two depths work.
  function automatic logic [PW-1:0] wrap_inc(
    input logic [PW-1:0] p
  );
    if (p == PW'(DEPTH-1))
      return '0;
    return p + PW'(1);
  endfunction

  assign pc_inc   = fetch_pc + ADDR_W'(PC_STEP);
  assign rom_addr = fetch_pc;

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;

  assign pop  = id_valid & id_ready;
  // A full queue may still accept when the head leaves this cycle.
  assign push = ~branch & (~full | pop);

  always_ff @(posedge clk or negedge R_n) begin
    if (!R_n) begin
      fetch_pc <= ADDR_W'(RESET_PC);
      head     <= '0;
      tail     <= '0;
      cnt      <= '0;
    end else if (branch) begin
      fetch_pc <= branch_target;
      head     <= '0;
      tail     <= '0;
      cnt      <= '0;
    end else begin
      if (push) begin
        tail     <= wrap_inc(tail);
        fetch_pc <= pc_inc;
      end
      if (pop)
        head <= wrap_inc(head);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage carries no reset; empty slots are masked on the outputs.
  always_ff @(posedge clk) begin
    if (push)
      mem[tail] <= '{instr: rom_data, npc: pc_inc};
  end

  assign head_e     = mem[head];
  assign id_valid   = ~empty;
  assign id_instr   = empty ? '0 : head_e.instr;
  assign id_next_pc = empty ? '0 : head_e.npc;

  a_cnt_max: assert property (
    @(posedge clk) disable iff (!R_n)
    cnt <= CW'(DEPTH)
  );

  a_full_empty: assert property (
    @(posedge clk) disable iff (!R_n)
    !(full && empty)
  );

  a_valid: assert property (
    @(posedge clk) disable iff (!R_n)
    id_valid == ~empty
  );

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: random and directed stimulus on two queue depths,
// checked against a queue-based reference model.
module tb_fetch_queue;

  typedef struct {
    logic [31:0] instr;
    logic [7:0]  npc;
  } ent_t;

  logic        clk = 0;
  logic        R_n = 0;
  logic        branch = 0;
  logic [7:0]  branch_target = '0;
  logic        id_ready = 0;

  logic [7:0]  ra4, np4;
  logic [31:0] rd4, in4;
  logic        v4, f4, e4;
  logic [2:0]  c4;

  logic [7:0]  ra3, np3;
  logic [31:0] rd3, in3;
  logic        v3, f3, e3;
  logic [1:0]  c3;

  int n_chk = 0;
  int n_pass = 0;

  ent_t q4[$];
  ent_t q3[$];
  logic [7:0] pc4, pc3;

  function automatic logic [31:0] rom(input logic [7:0] a);
    return 32'hE000_0000 + {26'b0, a[7:2]};
  endfunction

  assign rd4 = rom(ra4);
  assign rd3 = rom(ra3);

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(4)) u_dut4 (
    .clk(clk), .R_n(R_n),
    .rom_addr(ra4), .rom_data(rd4),
    .branch(branch), .branch_target(branch_target),
    .id_ready(id_ready), .id_valid(v4),
    .id_instr(in4), .id_next_pc(np4),
    .count(c4), .full(f4), .empty(e4)
  );

  fetch_queue #(.DEPTH(3)) u_dut3 (
    .clk(clk), .R_n(R_n),
    .rom_addr(ra3), .rom_data(rd3),
    .branch(branch), .branch_target(branch_target),
    .id_ready(id_ready), .id_valid(v3),
    .id_instr(in3), .id_next_pc(np3),
    .count(c3), .full(f3), .empty(e3)
  );

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
  endtask

  task automatic model_reset();
    q4.delete();
    q3.delete();
    pc4 = 8'h00;
    pc3 = 8'h00;
  endtask

  // Queue semantics: pop head if ready, append the fetched word if room.
  task automatic model_step();
    bit pp, ps;
    ent_t e;
    if (!R_n) begin
      model_reset();
      return;
    end
    if (branch) begin
      q4.delete();
      q3.delete();
      pc4 = branch_target;
      pc3 = branch_target;
      return;
    end
    pp = (q4.size() > 0) && id_ready;
    ps = (q4.size() < 4) || pp;
    if (pp) void'(q4.pop_front());
    if (ps) begin
      e.instr = rom(pc4);
      e.npc   = pc4 + 8'd4;
      q4.push_back(e);
      pc4 = pc4 + 8'd4;
    end
    pp = (q3.size() > 0) && id_ready;
    ps = (q3.size() < 3) || pp;
    if (pp) void'(q3.pop_front());
    if (ps) begin
      e.instr = rom(pc3);
      e.npc   = pc3 + 8'd4;
      q3.push_back(e);
      pc3 = pc3 + 8'd4;
    end
  endtask

  task automatic check_models();
    int s;
    s = q4.size();
    check("d4_addr", 64'(ra4), 64'(pc4));
    check("d4_cnt", 64'(c4), 64'(s));
    check("d4_valid", 64'(v4), 64'(s != 0));
    check("d4_full", 64'(f4), 64'(s == 4));
    check("d4_empty", 64'(e4), 64'(s == 0));
    check("d4_instr", 64'(in4),
          s != 0 ? 64'(q4[0].instr) : 64'(0));
    check("d4_npc", 64'(np4),
          s != 0 ? 64'(q4[0].npc) : 64'(0));
    s = q3.size();
    check("d3_addr", 64'(ra3), 64'(pc3));
    check("d3_cnt", 64'(c3), 64'(s));
    check("d3_valid", 64'(v3), 64'(s != 0));
    check("d3_full", 64'(f3), 64'(s == 3));
    check("d3_empty", 64'(e3), 64'(s == 0));
    check("d3_instr", 64'(in3),
          s != 0 ? 64'(q3[0].instr) : 64'(0));
    check("d3_npc", 64'(np3),
          s != 0 ? 64'(q3[0].npc) : 64'(0));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_models();
  endtask

  task automatic do_branch(input logic [7:0] t);
    branch = 1;
    branch_target = t;
    cyc();
    branch = 0;
  endtask

  initial begin
    model_reset();
    #1;
    check("rst_valid", 64'(v4), 64'(0));
    check("rst_empty", 64'(e4), 64'(1));
    check("rst_full", 64'(f4), 64'(0));
    check("rst_instr", 64'(in4), 64'(0));
    check("rst_npc", 64'(np4), 64'(0));
    check("rst_addr", 64'(ra4), 64'(0));
    cyc();
    check("rst_hold_cnt", 64'(c4), 64'(0));

    // reset and fill with a consumer always ready
    R_n = 1;
    id_ready = 1;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      check("fill_valid", 64'(v4), 64'(1));
      check("fill_instr", 64'(in4),
            64'(32'hE000_0000 + k - 1));
      check("fill_npc", 64'(np4), 64'(4 * k));
      check("fill_cnt", 64'(c4), 64'(1));
    end

    // stall to full
    do_branch(8'h00);
    id_ready = 0;
    for (int k = 0; k < 5; k++) cyc();
    check("stall_full", 64'(f4), 64'(1));
    check("stall_cnt", 64'(c4), 64'(4));
    check("stall_addr", 64'(ra4), 64'(8'h10));
    check("stall_instr", 64'(in4), 64'(32'hE000_0000));
    id_ready = 1;
    cyc();
    check("popfull_cnt", 64'(c4), 64'(4));
    check("popfull_addr", 64'(ra4), 64'(8'h14));
    check("popfull_instr", 64'(in4), 64'(32'hE000_0001));

    // branch flush with three entries
    do_branch(8'h00);
    id_ready = 0;
    for (int k = 0; k < 3; k++) cyc();
    check("pre_br_cnt", 64'(c4), 64'(3));
    id_ready = 1;
    do_branch(8'h40);
    id_ready = 0;
    check("br_empty", 64'(e4), 64'(1));
    check("br_addr", 64'(ra4), 64'(8'h40));
    cyc();
    check("br_instr", 64'(in4), 64'(32'hE000_0010));
    check("br_npc", 64'(np4), 64'(8'h44));

    // pc wraps modulo 256
    id_ready = 1;
    do_branch(8'hF8);
    check("pcw_addr0", 64'(ra4), 64'(8'hF8));
    cyc();
    check("pcw_npc0", 64'(np4), 64'(8'hFC));
    check("pcw_addr1", 64'(ra4), 64'(8'hFC));
    cyc();
    check("pcw_npc1", 64'(np4), 64'(8'h00));
    check("pcw_addr2", 64'(ra4), 64'(8'h00));
    cyc();
    check("pcw_npc2", 64'(np4), 64'(8'h04));

    // two pushes per pop across pointer wrap
    do_branch(8'h80);
    for (int i = 0; i < 21; i++) begin
      id_ready = (i % 3 == 2);
      cyc();
    end

    // random traffic
    for (int i = 0; i < 300; i++) begin
      branch = ($urandom_range(15) == 0);
      branch_target = 8'($urandom) & 8'hFC;
      id_ready = $urandom_range(1) == 1;
      cyc();
    end
    branch = 0;

    // asynchronous reset between edges
    do_branch(8'h20);
    id_ready = 0;
    cyc();
    cyc();
    check("ar_pre_cnt", 64'(c4), 64'(2));
    #2;
    R_n = 0;
    #1;
    check("ar_valid", 64'(v4), 64'(0));
    check("ar_cnt", 64'(c4), 64'(0));
    check("ar_addr", 64'(ra4), 64'(0));
    check("ar_cnt3", 64'(c3), 64'(0));
    model_reset();
    @(negedge clk);
    R_n = 1;
    id_ready = 1;
    cyc();
    check("ar_refetch_instr", 64'(in4), 64'(32'hE000_0000));
    check("ar_refetch_npc", 64'(np4), 64'(4));
    for (int i = 0; i < 8; i++) cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
